// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - FSM encodings and shared helpers for the pipeline trace monitor
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  // Counters narrower than 32 bits are passed zero-extended; w is their real width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  function automatic int unsigned entry_width(input int unsigned cnt_w,
                                              input int unsigned stages,
                                              input int unsigned tag_w);
    return cnt_w + stages * tag_w;
  endfunction

endpackage

// File: rtl/pipe_trace_monitor_ring_buf.sv
// rtl/pipe_trace_monitor_ring_buf.sv - DEPTH x WIDTH trace ring buffer with sticky overflow and registered read
module trace_ring_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_req,
  output logic                         wr_accept,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_fire, wr_fire, full_w;

  // A pop in the same cycle frees a slot, so a write into a full buffer still lands.
  always_comb begin
    full_w     = (count_q == CW'(DEPTH));
    rd_fire    = rd_req && (count_q != '0);
    wr_fire    = wr_en && (!full_w || rd_fire);
    wr_ptr_d   = wr_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_fire) - CW'(rd_fire);
    overflow_d = overflow_q | (wr_en && !wr_fire);
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign wr_accept = wr_fire;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = overflow_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// rtl/pipe_trace_monitor.sv - per-cycle pipeline PC tag tracer with cycle/retire/stall counters
// Optional build macro: TRACE_CHANGE_ONLY_EN (write a capture only when the tag vector changes)
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int PC_WIDTH    = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int CYCLE_LIMIT = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_STAGES*PC_WIDTH-1:0]    pc_flat,
  input  logic [NUM_STAGES-1:0]             stage_valid,
  input  logic                              capture_en,
  input  logic                              rd_req,
  output logic                              rd_valid,
  output logic [NUM_STAGES*TAG_WIDTH-1:0]   rd_data,
  output logic [CNT_WIDTH-1:0]              rd_cycle,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              overflow,
  output logic [CNT_WIDTH-1:0]              cycle_cnt,
  output logic [CNT_WIDTH-1:0]              retired_cnt,
  output logic [CNT_WIDTH-1:0]              stall_cnt,
  output logic                              done
);

  localparam int TAGS_W  = NUM_STAGES * TAG_WIDTH;
  localparam int ENTRY_W = int'(entry_width(CNT_WIDTH, NUM_STAGES, TAG_WIDTH));

  trace_state_e        state_q;
  logic                done_q;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, retired_q, retired_d, stall_q, stall_d;
  logic [TAG_WIDTH-1:0] last_tag0_q, last_tag0_d;
  logic [TAGS_W-1:0]    tags;
  logic [ENTRY_W-1:0]   rd_entry;
  logic                 wr_en, wr_accept;
  logic                 unused_inputs;

  always_comb begin
    tags = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      tags[i*TAG_WIDTH +: TAG_WIDTH] = pc_flat[i*PC_WIDTH +: TAG_WIDTH];
    end
  end

  assign unused_inputs = ^{pc_flat, stage_valid};

  always_comb begin
    cycle_d     = cycle_q;
    retired_d   = retired_q;
    stall_d     = stall_q;
    last_tag0_d = tags[TAG_WIDTH-1:0];
    if (state_q != ST_DONE) cycle_d = CNT_WIDTH'(sat_inc(32'(cycle_q), CNT_WIDTH));
    if (state_q == ST_RUN) begin
      if (stage_valid[NUM_STAGES-1]) retired_d = CNT_WIDTH'(sat_inc(32'(retired_q), CNT_WIDTH));
      if (stage_valid[0] && (tags[TAG_WIDTH-1:0] == last_tag0_q))
        stall_d = CNT_WIDTH'(sat_inc(32'(stall_q), CNT_WIDTH));
    end
  end

`ifdef TRACE_CHANGE_ONLY_EN
  logic [TAGS_W-1:0] last_vec_q, last_vec_d;
  logic              have_wr_q, have_wr_d;

  always_comb begin
    wr_en      = (state_q == ST_RUN) && capture_en && (!have_wr_q || (tags != last_vec_q));
    last_vec_d = wr_accept ? tags : last_vec_q;
    have_wr_d  = have_wr_q | wr_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_vec_q <= '0;
      have_wr_q  <= 1'b0;
    end else begin
      last_vec_q <= last_vec_d;
      have_wr_q  <= have_wr_d;
    end
  end
`else
  logic unused_wr_accept;

  assign wr_en            = (state_q == ST_RUN) && capture_en;
  assign unused_wr_accept = wr_accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      retired_q   <= '0;
      stall_q     <= '0;
      last_tag0_q <= '0;
    end else begin
      cycle_q     <= cycle_d;
      retired_q   <= retired_d;
      stall_q     <= stall_d;
      last_tag0_q <= last_tag0_d;
    end
  end

  // The capture in the final RUN cycle still happens; DRAIN waits for the reader to empty the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cycle_q == CNT_WIDTH'(CYCLE_LIMIT - 1)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((count == '0) && !wr_en) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  trace_ring_buf #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   ({cycle_q, tags}),
    .rd_req    (rd_req),
    .wr_accept (wr_accept),
    .rd_valid  (rd_valid),
    .rd_data   (rd_entry),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  assign rd_cycle    = rd_entry[ENTRY_W-1 -: CNT_WIDTH];
  assign rd_data     = rd_entry[TAGS_W-1:0];
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// tb/tb_pipe_trace_monitor.sv - self-checking bench for pipe_trace_monitor against a queue-based model
module tb_pipe_trace_monitor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [159:0] pc_flat = '0;
  logic [4:0]   stage_valid = '0;
  logic         capture_en = 1'b0;
  logic         rd_req = 1'b0;

  logic        a_rd_valid, a_full, a_overflow, a_done;
  logic [19:0] a_rd_data;
  logic [15:0] a_rd_cycle, a_cycle_cnt, a_retired_cnt, a_stall_cnt;
  logic [4:0]  a_count;
  logic        b_rd_valid, b_full, b_overflow, b_done;
  logic [19:0] b_rd_data;
  logic [15:0] b_rd_cycle, b_cycle_cnt, b_retired_cnt, b_stall_cnt;
  logic [2:0]  b_count;

  pipe_trace_monitor #(.DEPTH(16), .CYCLE_LIMIT(10)) dut_a (
    .clk(clk), .rst(rst), .pc_flat(pc_flat), .stage_valid(stage_valid),
    .capture_en(capture_en), .rd_req(rd_req), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .rd_cycle(a_rd_cycle), .count(a_count), .full(a_full), .overflow(a_overflow),
    .cycle_cnt(a_cycle_cnt), .retired_cnt(a_retired_cnt), .stall_cnt(a_stall_cnt), .done(a_done));

  pipe_trace_monitor #(.DEPTH(4), .CYCLE_LIMIT(1000)) dut_b (
    .clk(clk), .rst(rst), .pc_flat(pc_flat), .stage_valid(stage_valid),
    .capture_en(capture_en), .rd_req(rd_req), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .rd_cycle(b_rd_cycle), .count(b_count), .full(b_full), .overflow(b_overflow),
    .cycle_cnt(b_cycle_cnt), .retired_cnt(b_retired_cnt), .stall_cnt(b_stall_cnt), .done(b_done));

  always #5 clk = ~clk;

  // sel picks which instance is observed and which geometry the model uses
  bit          sel = 1'b0;
  logic [7:0]  o_count;
  logic        o_full, o_ovf, o_done, o_rdv;
  logic [19:0] o_rdd;
  logic [15:0] o_rdc, o_cyc, o_ret, o_stall;

  assign o_count = sel ? 8'(b_count) : 8'(a_count);
  assign o_full  = sel ? b_full : a_full;
  assign o_ovf   = sel ? b_overflow : a_overflow;
  assign o_done  = sel ? b_done : a_done;
  assign o_rdv   = sel ? b_rd_valid : a_rd_valid;
  assign o_rdd   = sel ? b_rd_data : a_rd_data;
  assign o_rdc   = sel ? b_rd_cycle : a_rd_cycle;
  assign o_cyc   = sel ? b_cycle_cnt : a_cycle_cnt;
  assign o_ret   = sel ? b_retired_cnt : a_retired_cnt;
  assign o_stall = sel ? b_stall_cnt : a_stall_cnt;

  int checks = 0;
  int failures = 0;
  bit chg_only = 1'b0;

  typedef struct {
    logic [15:0] cyc;
    logic [19:0] tags;
  } ent_t;

  ent_t        mq[$];
  int          m_phase;   // 0 capturing, 1 draining, 2 finished
  int unsigned m_cycle, m_retired, m_stall;
  logic [3:0]  m_prev_tag0;
  logic        m_ovf, m_rdv, m_have;
  logic [19:0] m_rdd, m_last;
  logic [15:0] m_rdc;

  function automatic int unsigned sat16(input int unsigned v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_step();
    logic [19:0] tg;
    int          sz;
    bit          want;
    int unsigned old_cycle;
    ent_t        e;
    int          depth, limit;
    depth = sel ? 4 : 16;
    limit = sel ? 1000 : 10;
    if (rst) begin
      mq.delete();
      m_phase = 0; m_cycle = 0; m_retired = 0; m_stall = 0; m_prev_tag0 = '0;
      m_ovf = 0; m_rdv = 0; m_rdd = '0; m_rdc = '0; m_have = 0; m_last = '0;
      return;
    end
    for (int i = 0; i < 5; i++) tg[i*4 +: 4] = 4'(pc_flat[i*32 +: 32] % 16);
    sz   = mq.size();
    want = (m_phase == 0) && capture_en;
    if (chg_only && m_have && (tg == m_last)) want = 0;
    m_rdv = 0;
    if (rd_req && sz > 0) begin
      e = mq.pop_front();
      m_rdv = 1; m_rdd = e.tags; m_rdc = e.cyc;
    end
    if (want) begin
      if (mq.size() < depth) begin
        e.cyc = 16'(m_cycle); e.tags = tg;
        mq.push_back(e);
        m_have = 1; m_last = tg;
      end else begin
        m_ovf = 1;
      end
    end
    if (m_phase == 0) begin
      if (stage_valid[4]) m_retired = sat16(m_retired);
      if (stage_valid[0] && (tg[3:0] == m_prev_tag0)) m_stall = sat16(m_stall);
    end
    m_prev_tag0 = tg[3:0];
    old_cycle = m_cycle;
    if (m_phase != 2) m_cycle = sat16(m_cycle);
    if (m_phase == 0 && old_cycle == limit - 1) m_phase = 1;
    else if (m_phase == 1 && sz == 0) m_phase = 2;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pcs(input logic [3:0] t0);
    for (int i = 0; i < 5; i++) pc_flat[i*32 +: 32] = $urandom;
    pc_flat[3:0] = t0;
  endtask

  task automatic do_reset();
    rst = 1; capture_en = 0; rd_req = 0; stage_valid = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    sel = 0;
    capture_en = 1; rd_req = 1; stage_valid = '1;
    do_reset();
    checks++; if (o_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if ({o_full, o_ovf, o_done, o_rdv} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {o_full, o_ovf, o_done, o_rdv}); end
    checks++; if ({o_cyc, o_ret, o_stall} !== 48'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", o_cyc, o_ret, o_stall); end
    checks++; if ({o_rdd, o_rdc} !== 36'd0) begin failures++; $display("FAIL reset_rd_regs got=%h/%h exp=0", o_rdd, o_rdc); end
  endtask

  task automatic test_capture_window();
    int k;
    sel = 0;
    do_reset();
    capture_en = 1;
    for (int c = 0; c < 10; c++) begin
      drive_pcs(4'(c));
      tick();
    end
    checks++; if (o_count !== 8'd10) begin failures++; $display("FAIL window_count got=%0d exp=10", o_count); end
    checks++; if (o_done !== 1'b0 || m_phase != 1) begin failures++; $display("FAIL window_drain got_done=%b model_phase=%0d exp=0/1", o_done, m_phase); end
    drive_pcs(4'd15);
    tick();
    checks++; if (o_count !== 8'd10) begin failures++; $display("FAIL window_no_capture_in_drain got=%0d exp=10", o_count); end
    capture_en = 0; rd_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (o_rdv !== 1'b1 || o_rdc !== 16'(i)) begin failures++; $display("FAIL window_pop%0d got_v=%b got_cycle=%0d exp=1/%0d", i, o_rdv, o_rdc, i); end
      checks++; if (o_rdd !== m_rdd) begin failures++; $display("FAIL window_pop_data%0d got=%h exp=%h", i, o_rdd, m_rdd); end
    end
    rd_req = 0;
    k = 0;
    while (o_done !== 1'b1 && k < 8) begin tick(); k++; end
    checks++; if (o_done !== 1'b1 || k != 1) begin failures++; $display("FAIL window_done got=%b after=%0d exp=1 after 1", o_done, k); end
    checks++; if (o_cyc !== 16'(m_cycle)) begin failures++; $display("FAIL window_cycle got=%0d exp=%0d", o_cyc, m_cycle); end
    tick(); tick();
    checks++; if (o_cyc !== 16'(m_cycle) || o_done !== 1'b1) begin failures++; $display("FAIL done_frozen got=%0d exp=%0d", o_cyc, m_cycle); end
    rd_req = 1;
    tick();
    checks++; if (o_rdv !== 1'b0) begin failures++; $display("FAIL done_empty_read got=%b exp=0", o_rdv); end
    rd_req = 0;
  endtask

  task automatic test_full_overflow();
    sel = 1;
    do_reset();
    capture_en = 1;
    for (int c = 0; c < 6; c++) begin drive_pcs(4'(c)); tick(); end
    capture_en = 0;
    checks++; if (o_count !== 8'd4 || o_full !== 1'b1) begin failures++; $display("FAIL full_count got=%0d/%b exp=4/1", o_count, o_full); end
    checks++; if (o_ovf !== 1'b1) begin failures++; $display("FAIL full_overflow got=%b exp=1", o_ovf); end
    rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (o_rdv !== 1'b1 || o_rdc !== 16'(i)) begin failures++; $display("FAIL full_pop%0d got=%b/%0d exp=1/%0d", i, o_rdv, o_rdc, i); end
    end
    tick();
    checks++; if (o_rdv !== 1'b0 || o_count !== 8'd0 || o_ovf !== 1'b1) begin failures++; $display("FAIL full_drained got=%b/%0d/%b exp=0/0/1", o_rdv, o_count, o_ovf); end
    rd_req = 0;
  endtask

  task automatic test_full_simultaneous();
    sel = 1;
    do_reset();
    capture_en = 1;
    for (int c = 0; c < 4; c++) begin drive_pcs(4'(c)); tick(); end
    drive_pcs(4'd9); rd_req = 1;
    tick();
    capture_en = 0; rd_req = 0;
    checks++; if (o_count !== 8'd4 || o_ovf !== 1'b0) begin failures++; $display("FAIL simul_count got=%0d/%b exp=4/0", o_count, o_ovf); end
    checks++; if (o_rdv !== 1'b1 || o_rdc !== 16'd0) begin failures++; $display("FAIL simul_oldest got=%b/%0d exp=1/0", o_rdv, o_rdc); end
    tick();
    checks++; if (o_rdv !== 1'b0 || o_rdc !== 16'd0) begin failures++; $display("FAIL simul_hold got=%b/%0d exp=0/0", o_rdv, o_rdc); end
  endtask

  task automatic test_counters();
    sel = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive_pcs(c < 3 ? 4'hC : 4'(c));
      stage_valid = {1'b1, 3'($urandom), (c < 3) ? 1'b1 : 1'b0};
      tick();
    end
    stage_valid = '0;
    checks++; if (o_stall !== 16'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", o_stall); end
    checks++; if (o_ret !== 16'd5) begin failures++; $display("FAIL retired_cnt got=%0d exp=5", o_ret); end
  endtask

  task automatic test_empty_read();
    sel = 0;
    do_reset();
    rd_req = 1;
    tick();
    checks++; if (o_rdv !== 1'b0 || o_count !== 8'd0) begin failures++; $display("FAIL empty_read got=%b/%0d exp=0/0", o_rdv, o_count); end
    rd_req = 0; capture_en = 1; drive_pcs(4'd3);
    tick();
    capture_en = 0; rd_req = 1;
    tick();
    checks++; if (o_rdv !== 1'b1) begin failures++; $display("FAIL single_pop got=%b exp=1", o_rdv); end
    tick();
    checks++; if (o_rdv !== 1'b0) begin failures++; $display("FAIL single_pop_pulse got=%b exp=0", o_rdv); end
    rd_req = 0;
  endtask

  task automatic test_reset_in_drain();
    sel = 0;
    do_reset();
    capture_en = 1;
    for (int c = 0; c < 10; c++) begin drive_pcs(4'(c)); tick(); end
    capture_en = 0; rd_req = 1;
    for (int i = 0; i < 7; i++) tick();
    rd_req = 0;
    checks++; if (o_count !== 8'd3 || o_done !== 1'b0) begin failures++; $display("FAIL pre_reset got=%0d/%b exp=3/0", o_count, o_done); end
    do_reset();
    checks++; if (o_count !== 8'd0 || o_done !== 1'b0 || o_cyc !== 16'd0) begin failures++; $display("FAIL drain_reset got=%0d/%b/%0d exp=0/0/0", o_count, o_done, o_cyc); end
    capture_en = 1; drive_pcs(4'd1);
    tick();
    capture_en = 0;
    checks++; if (o_count !== 8'd1 || o_cyc !== 16'd1) begin failures++; $display("FAIL run_after_reset got=%0d/%0d exp=1/1", o_count, o_cyc); end
  endtask

  task automatic test_change_only();
    int exp_n;
    sel = 0;
    exp_n = chg_only ? 2 : 5;
    do_reset();
    capture_en = 1;
    drive_pcs(4'h7);
    for (int c = 0; c < 4; c++) tick();
    pc_flat[3:0] = 4'h8;
    tick();
    capture_en = 0;
    checks++; if (o_count !== 8'(exp_n) || mq.size() != exp_n) begin failures++; $display("FAIL change_only got=%0d model=%0d exp=%0d", o_count, mq.size(), exp_n); end
    checks++; if (o_ovf !== 1'b0) begin failures++; $display("FAIL change_only_ovf got=%b exp=0", o_ovf); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      sel = r[0];
      do_reset();
      for (int c = 0; c < 60; c++) begin
        rst = ($urandom_range(0, 59) == 0);
        capture_en = ($urandom_range(0, 3) != 0);
        rd_req = ($urandom_range(0, 2) == 0);
        stage_valid = 5'($urandom);
        for (int i = 0; i < 5; i++) pc_flat[i*32 +: 32] = {$urandom} & 32'hFFFF_FFF3;
        tick();
        checks++;
        if (o_count !== 8'(mq.size()) || o_full !== (mq.size() == (sel ? 4 : 16)) ||
            o_ovf !== m_ovf || o_done !== (m_phase == 2)) begin
          failures++;
          $display("FAIL rand_buf r=%0d c=%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b", r, c,
                   o_count, o_full, o_ovf, o_done, mq.size(), mq.size() == (sel ? 4 : 16), m_ovf, m_phase == 2);
        end
        checks++;
        if (o_cyc !== 16'(m_cycle) || o_ret !== 16'(m_retired) || o_stall !== 16'(m_stall)) begin
          failures++;
          $display("FAIL rand_cnt r=%0d c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", r, c,
                   o_cyc, o_ret, o_stall, m_cycle, m_retired, m_stall);
        end
        checks++;
        if (o_rdv !== m_rdv || o_rdd !== m_rdd || o_rdc !== m_rdc) begin
          failures++;
          $display("FAIL rand_rd r=%0d c=%0d got=%b/%h/%0d exp=%b/%h/%0d", r, c,
                   o_rdv, o_rdd, o_rdc, m_rdv, m_rdd, m_rdc);
        end
      end
      rst = 0;
    end
    capture_en = 0; rd_req = 0;
  endtask

  initial begin
`ifdef TRACE_CHANGE_ONLY_EN
    chg_only = 1'b1;
`endif
    test_reset();
    test_capture_window();
    test_full_overflow();
    test_full_simultaneous();
    test_counters();
    test_empty_read();
    test_reset_in_drain();
    test_change_only();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
